// File: rtl/morse_pkg.sv
// Shared Morse definitions: code format, encoder states, timing constants and
// the ASCII-to-Morse lookup used by both the encoder and the decoder.
package morse_pkg;

   typedef struct packed {
      logic [2:0] len;
      logic [4:0] pattern;
   } morse_code_t;

   typedef struct packed {
      logic        valid;
      morse_code_t code;
   } morse_lookup_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MARK,
      ST_ELEM_GAP,
      ST_CHAR_GAP,
      ST_WORD,
      ST_ERR
   } encoder_state_t;

   localparam logic [2:0] DOT_UNITS        = 3'd1;
   localparam logic [2:0] DASH_UNITS       = 3'd3;
   localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
   localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
   localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

   // Pattern bit len-1 is the first element sent; 1 = dash, 0 = dot.
   function automatic morse_lookup_t ascii_to_morse(input logic [7:0] c);
      logic [7:0]  u;
      morse_code_t code;
      logic        ok;
      u    = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
      ok   = 1'b1;
      code = '0;
      case (u)
         "A": code = {3'd2, 5'b00001};
         "B": code = {3'd4, 5'b01000};
         "C": code = {3'd4, 5'b01010};
         "D": code = {3'd3, 5'b00100};
         "E": code = {3'd1, 5'b00000};
         "F": code = {3'd4, 5'b00010};
         "G": code = {3'd3, 5'b00110};
         "H": code = {3'd4, 5'b00000};
         "I": code = {3'd2, 5'b00000};
         "J": code = {3'd4, 5'b00111};
         "K": code = {3'd3, 5'b00101};
         "L": code = {3'd4, 5'b00100};
         "M": code = {3'd2, 5'b00011};
         "N": code = {3'd2, 5'b00010};
         "O": code = {3'd3, 5'b00111};
         "P": code = {3'd4, 5'b00110};
         "Q": code = {3'd4, 5'b01101};
         "R": code = {3'd3, 5'b00010};
         "S": code = {3'd3, 5'b00000};
         "T": code = {3'd1, 5'b00001};
         "U": code = {3'd3, 5'b00001};
         "V": code = {3'd4, 5'b00001};
         "W": code = {3'd3, 5'b00011};
         "X": code = {3'd4, 5'b01001};
         "Y": code = {3'd4, 5'b01011};
         "Z": code = {3'd4, 5'b01100};
         "0": code = {3'd5, 5'b11111};
         "1": code = {3'd5, 5'b01111};
         "2": code = {3'd5, 5'b00111};
         "3": code = {3'd5, 5'b00011};
         "4": code = {3'd5, 5'b00001};
         "5": code = {3'd5, 5'b00000};
         "6": code = {3'd5, 5'b10000};
         "7": code = {3'd5, 5'b11000};
         "8": code = {3'd5, 5'b11100};
         "9": code = {3'd5, 5'b11110};
         default: ok = 1'b0;
      endcase
      return '{valid: ok, code: code};
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Interval timer: after start, done pulses on the last cycle of a
// units*UNIT_CYCLES interval. start reloads even while running.
module morse_unit_timer #(
   parameter int UNIT_CYCLES = 6000000,
   parameter int CNT_W       = $clog2(7 * UNIT_CYCLES)
) (
   input  logic       clk_100Mhz,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] units,
   output logic       done
);

   localparam logic [CNT_W-1:0] UNIT_W = CNT_W'(UNIT_CYCLES);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] target;
   logic             running;

   assign done = running && (cnt == target);

   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         target  <= '0;
         running <= 1'b0;
      end else if (start) begin
         cnt     <= '0;
         target  <= CNT_W'(units) * UNIT_W - CNT_W'(1);
         running <= 1'b1;
      end else if (done) begin
         running <= 1'b0;
      end else if (running) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/morse_encoder.sv
// ASCII-to-Morse transmitter: accepts one character over valid/ready and keys
// the output line with standard Morse element and gap timing.
module morse_encoder
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 6000000,
   parameter int CNT_W       = $clog2(7 * UNIT_CYCLES)
) (
   input  logic           clk_100Mhz,
   input  logic           reset,
   input  logic [7:0]     char_in,
   input  logic           char_valid,
   output logic           char_ready,
   output logic           key_out,
   output logic           busy,
   output logic           char_err,
   output encoder_state_t state_dbg
);

   // Handshake: a character transfers on a rising edge where char_valid and
   // char_ready are both high; char_ready depends only on the registered state.

   encoder_state_t state, state_n;
   logic [4:0]     pat_q, pat_n;
   logic [2:0]     idx_q, idx_n;
   logic           tmr_start;
   logic [2:0]     tmr_units;
   logic           tmr_done;
   morse_lookup_t  lk;
   logic [2:0]     first_idx;
   logic [2:0]     idx_dec;

   assign lk        = ascii_to_morse(char_in);
   assign first_idx = lk.code.len - 3'd1;
   assign idx_dec   = idx_q - 3'd1;

   morse_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk_100Mhz (clk_100Mhz),
      .reset      (reset),
      .start      (tmr_start),
      .units      (tmr_units),
      .done       (tmr_done)
   );

   always_comb begin
      state_n   = state;
      pat_n     = pat_q;
      idx_n     = idx_q;
      tmr_start = 1'b0;
      tmr_units = 3'd0;
      case (state)
         ST_IDLE: begin
            if (char_valid) begin
               if (char_in == 8'h20) begin
                  state_n   = ST_WORD;
                  tmr_start = 1'b1;
                  tmr_units = WORD_EXTRA_UNITS;
               end else if (lk.valid) begin
                  state_n   = ST_MARK;
                  pat_n     = lk.code.pattern;
                  idx_n     = first_idx;
                  tmr_start = 1'b1;
                  tmr_units = lk.code.pattern[first_idx] ? DASH_UNITS : DOT_UNITS;
               end else begin
                  state_n = ST_ERR;
               end
            end
         end
         ST_MARK: begin
            if (tmr_done) begin
               tmr_start = 1'b1;
               if (idx_q != 3'd0) begin
                  state_n   = ST_ELEM_GAP;
                  tmr_units = ELEM_GAP_UNITS;
               end else begin
                  state_n   = ST_CHAR_GAP;
                  tmr_units = CHAR_GAP_UNITS;
               end
            end
         end
         ST_ELEM_GAP: begin
            if (tmr_done) begin
               state_n   = ST_MARK;
               idx_n     = idx_dec;
               tmr_start = 1'b1;
               tmr_units = pat_q[idx_dec] ? DASH_UNITS : DOT_UNITS;
            end
         end
         ST_CHAR_GAP, ST_WORD: begin
            if (tmr_done) state_n = ST_IDLE;
         end
         ST_ERR:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         pat_q   <= '0;
         idx_q   <= '0;
         key_out <= 1'b0;
      end else begin
         state   <= state_n;
         pat_q   <= pat_n;
         idx_q   <= idx_n;
         key_out <= (state_n == ST_MARK);
      end
   end

   assign char_ready = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign char_err   = (state == ST_ERR);
   assign state_dbg  = state;

endmodule

// File: tb/tb_morse_encoder.sv
// Randomised bench for morse_encoder: a string-table Morse model predicts each
// character's key/err trace, and a monitor compares the captured traces.
module tb_morse_encoder;
   import morse_pkg::*;

   localparam int U = 4;

   logic           clk_100Mhz = 1'b0;
   logic           reset;
   logic [7:0]     char_in;
   logic           char_valid;
   logic           char_ready;
   logic           key_out;
   logic           busy;
   logic           char_err;
   encoder_state_t state_dbg;

   int vectors = 0;
   int fails   = 0;

   logic [127:0] exp_trace_q[$];
   logic [127:0] exp_err_q[$];
   logic [7:0]   exp_len_q[$];

   morse_encoder #(.UNIT_CYCLES(U)) dut (
      .clk_100Mhz (clk_100Mhz),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .key_out    (key_out),
      .busy       (busy),
      .char_err   (char_err),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk_100Mhz = ~clk_100Mhz;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic string morse_of(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
      case (u)
         "A": return ".-";    "B": return "-...";  "C": return "-.-.";
         "D": return "-..";   "E": return ".";     "F": return "..-.";
         "G": return "--.";   "H": return "....";  "I": return "..";
         "J": return ".---";  "K": return "-.-";   "L": return ".-..";
         "M": return "--";    "N": return "-.";    "O": return "---";
         "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
         "S": return "...";   "T": return "-";     "U": return "..-";
         "V": return "...-";  "W": return ".--";   "X": return "-..-";
         "Y": return "-.--";  "Z": return "--..";
         "0": return "-----"; "1": return ".----"; "2": return "..---";
         "3": return "...--"; "4": return "....-"; "5": return ".....";
         "6": return "-...."; "7": return "--..."; "8": return "---..";
         "9": return "----.";
         default: return "";
      endcase
   endfunction

   // Bit i of each trace is the value during cycle i+1 after the accept.
   task automatic model(input logic [7:0] c, output logic [127:0] tr,
                        output logic [127:0] er, output int len);
      string s;
      int    n;
      tr  = '0;
      er  = '0;
      len = 0;
      s   = morse_of(c);
      if (c == 8'h20) begin
         len = 4 * U;
      end else if (s.len() == 0) begin
         er[0] = 1'b1;
         len   = 1;
      end else begin
         for (int k = 0; k < s.len(); k++) begin
            n = (s[k] == 8'h2D) ? 3 * U : U;
            for (int j = 0; j < n; j++) tr[len + j] = 1'b1;
            len += n;
            if (k < s.len() - 1) len += U;
         end
         len += 3 * U;
      end
   endtask

   // ---------------- driver ----------------
   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] c, input int hold);
      logic [127:0] t, e;
      int l, waited, h;
      model(c, t, e, l);
      waited = 0;
      @(posedge clk_100Mhz); #1;
      while (!char_ready && waited < 500) begin
         @(posedge clk_100Mhz); #1;
         waited++;
      end
      if (!char_ready) begin
         check("ready_timeout", 128'(char_ready), 128'd1);
         return;
      end
      char_in    = c;
      char_valid = 1'b1;
      exp_trace_q.push_back(t);
      exp_err_q.push_back(e);
      exp_len_q.push_back(8'(l));
      @(posedge clk_100Mhz); #1;
      h = (hold > l - 1) ? l - 1 : hold;
      char_in = 8'($urandom);
      repeat (h) @(posedge clk_100Mhz);
      #1;
      char_valid = 1'b0;
   endtask

   function automatic logic [7:0] rand_char();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 3)      return 8'("A" + $urandom_range(0, 25));
      else if (sel <= 5) return 8'("a" + $urandom_range(0, 25));
      else if (sel <= 7) return 8'("0" + $urandom_range(0, 9));
      else if (sel == 8) return 8'h20;
      else               return 8'($urandom_range(0, 255));
   endfunction

   // ---------------- monitor / scoreboard ----------------
   logic         capturing = 1'b0;
   int           cap_idx   = 0;
   logic [127:0] cap_trace, cap_err;

   always @(negedge clk_100Mhz) begin
      if (!reset) begin
         if (capturing) begin
            if (exp_len_q.size() > 0) begin
               void'(exp_trace_q.pop_front());
               void'(exp_err_q.pop_front());
               void'(exp_len_q.pop_front());
            end
            capturing = 1'b0;
         end
      end else begin
         if (capturing) begin
            if (char_ready || cap_idx >= 200) begin
               capturing = 1'b0;
               if (exp_len_q.size() == 0) begin
                  check("spurious_accept", 128'd1, 128'd0);
               end else begin
                  check("trace_len", 128'(cap_idx), 128'(exp_len_q.pop_front()));
                  check("key_trace", cap_trace, exp_trace_q.pop_front());
                  check("err_trace", cap_err, exp_err_q.pop_front());
               end
            end else begin
               if (cap_idx < 128) begin
                  cap_trace[cap_idx] = key_out;
                  cap_err[cap_idx]   = char_err;
               end
               cap_idx++;
            end
         end
         if (!capturing && char_valid && char_ready) begin
            capturing = 1'b1;
            cap_idx   = 0;
            cap_trace = '0;
            cap_err   = '0;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int waited;
      reset      = 1'b0;
      char_in    = 8'h00;
      char_valid = 1'b0;
      #1;
      check("rst_key",   128'(key_out),    128'd0);
      check("rst_ready", 128'(char_ready), 128'd1);
      check("rst_busy",  128'(busy),       128'd0);
      check("rst_err",   128'(char_err),   128'd0);
      repeat (3) @(posedge clk_100Mhz);
      #2 reset = 1'b1;

      send("E", 0);
      send("A", 100);
      send("0", 0);
      send("e", 0);
      send(8'h20, 0);
      send("E", 0);
      send(8'h20, 0);
      send("E", 0);
      send("#", 0);

      // Asynchronous reset in the middle of a dash.
      send("T", 0);
      repeat (5) @(posedge clk_100Mhz);
      #2 reset = 1'b0;
      #1;
      check("midreset_key",   128'(key_out),    128'd0);
      check("midreset_ready", 128'(char_ready), 128'd1);
      check("midreset_busy",  128'(busy),       128'd0);
      @(posedge clk_100Mhz);
      #2 reset = 1'b1;
      send("E", 0);

      for (int i = 0; i < 40; i++) send(rand_char(), $urandom_range(0, 20));

      waited = 0;
      while ((exp_len_q.size() != 0 || capturing) && waited < 500) begin
         @(posedge clk_100Mhz);
         waited++;
      end
      check("queue_drained", 128'(exp_len_q.size()), 128'd0);
      repeat (4) @(posedge clk_100Mhz);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
